// File: rtl/sdram_pkg.sv
// Shared types and width constants for the SDRAM request bridge and the control cores.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 23;
    localparam int SDRAM_DATA_W = 32;
    localparam logic [31:0] SDRAM_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } sdram_bridge_state_t;

endpackage

// File: rtl/sdram_req_bridge_if.sv
// Core-side request handshake plus the Avalon-MM s1 bus of the SDRAM controller.
// slave = bridge view, master = requester/controller environment view.
interface sdram_req_bridge_if
    import sdram_pkg::*;
#(
    parameter int ADDR_W = SDRAM_ADDR_W,
    parameter int DATA_W = SDRAM_DATA_W
);
    logic              sdram_read;
    logic              sdram_write;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DATA_W-1:0] sdram_writedata;
    logic [DATA_W-1:0] sdram_readdata;
    logic              sdram_finished;
    logic              sdram_busy;
    logic              sdram_error;

    logic [ADDR_W-1:0] new_sdram_controller_0_s1_address;
    logic [3:0]        new_sdram_controller_0_s1_byteenable_n;
    logic              new_sdram_controller_0_s1_chipselect;
    logic [DATA_W-1:0] new_sdram_controller_0_s1_writedata;
    logic              new_sdram_controller_0_s1_read_n;
    logic              new_sdram_controller_0_s1_write_n;
    logic [DATA_W-1:0] new_sdram_controller_0_s1_readdata;
    logic              new_sdram_controller_0_s1_readdatavalid;
    logic              new_sdram_controller_0_s1_waitrequest;

    modport slave (
        input  sdram_read, sdram_write, sdram_addr, sdram_writedata,
        output sdram_readdata, sdram_finished, sdram_busy, sdram_error,
        output new_sdram_controller_0_s1_address, new_sdram_controller_0_s1_byteenable_n,
        output new_sdram_controller_0_s1_chipselect, new_sdram_controller_0_s1_writedata,
        output new_sdram_controller_0_s1_read_n, new_sdram_controller_0_s1_write_n,
        input  new_sdram_controller_0_s1_readdata, new_sdram_controller_0_s1_readdatavalid,
        input  new_sdram_controller_0_s1_waitrequest
    );

    modport master (
        output sdram_read, sdram_write, sdram_addr, sdram_writedata,
        input  sdram_readdata, sdram_finished, sdram_busy, sdram_error,
        input  new_sdram_controller_0_s1_address, new_sdram_controller_0_s1_byteenable_n,
        input  new_sdram_controller_0_s1_chipselect, new_sdram_controller_0_s1_writedata,
        input  new_sdram_controller_0_s1_read_n, new_sdram_controller_0_s1_write_n,
        output new_sdram_controller_0_s1_readdata, new_sdram_controller_0_s1_readdatavalid,
        output new_sdram_controller_0_s1_waitrequest
    );

endinterface

// File: rtl/sdram_req_bridge.sv
// Turns one held core request into a single Avalon-MM transaction on s1 and returns a finished pulse.
// Optional watchdog: define SDRAM_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYC cycles.
module sdram_req_bridge
    import sdram_pkg::*;
#(
    parameter int ADDR_W      = SDRAM_ADDR_W,
    parameter int DATA_W      = SDRAM_DATA_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic               i_clk,
    input logic               i_rst,
    sdram_req_bridge_if.slave bus
);

    sdram_bridge_state_t state;

    assign bus.new_sdram_controller_0_s1_byteenable_n = 4'b0000;

`ifdef SDRAM_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] wdog_cnt;
    logic        wdog_hit;

    assign wdog_hit = (wdog_cnt == WDOG_LAST);

    // Zero outside a transaction, so it is already clear on entry to RD_REQ/WR_REQ.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wdog_cnt <= '0;
        end else if (state == RD_REQ || state == RD_WAIT || state == WR_REQ) begin
            wdog_cnt <= wdog_cnt + 16'd1;
        end else begin
            wdog_cnt <= '0;
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign bus.sdram_error = 1'b0;
`endif

    // Avalon command outputs are registered together with the state so they change only on edges.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state                                   <= IDLE;
            bus.new_sdram_controller_0_s1_chipselect <= 1'b0;
            bus.new_sdram_controller_0_s1_read_n     <= 1'b1;
            bus.new_sdram_controller_0_s1_write_n    <= 1'b1;
            bus.new_sdram_controller_0_s1_address    <= '0;
            bus.new_sdram_controller_0_s1_writedata  <= '0;
            bus.sdram_readdata                       <= '0;
            bus.sdram_finished                       <= 1'b0;
            bus.sdram_busy                           <= 1'b0;
`ifdef SDRAM_TIMEOUT_EN
            bus.sdram_error                          <= 1'b0;
`endif
        end else begin
            bus.sdram_finished <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sdram_write) begin
                        state                                   <= WR_REQ;
                        bus.new_sdram_controller_0_s1_address    <= bus.sdram_addr;
                        bus.new_sdram_controller_0_s1_writedata  <= bus.sdram_writedata;
                        bus.new_sdram_controller_0_s1_chipselect <= 1'b1;
                        bus.new_sdram_controller_0_s1_write_n    <= 1'b0;
                        bus.sdram_busy                           <= 1'b1;
                    end else if (bus.sdram_read) begin
                        state                                   <= RD_REQ;
                        bus.new_sdram_controller_0_s1_address    <= bus.sdram_addr;
                        bus.new_sdram_controller_0_s1_chipselect <= 1'b1;
                        bus.new_sdram_controller_0_s1_read_n     <= 1'b0;
                        bus.sdram_busy                           <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (!bus.new_sdram_controller_0_s1_waitrequest) begin
                        state                                   <= RD_WAIT;
                        bus.new_sdram_controller_0_s1_chipselect <= 1'b0;
                        bus.new_sdram_controller_0_s1_read_n     <= 1'b1;
                    end
`ifdef SDRAM_TIMEOUT_EN
                    else if (wdog_hit) begin
                        state                                   <= DONE;
                        bus.new_sdram_controller_0_s1_chipselect <= 1'b0;
                        bus.new_sdram_controller_0_s1_read_n     <= 1'b1;
                        bus.sdram_readdata                       <= DATA_W'(SDRAM_TIMEOUT_DATA);
                        bus.sdram_finished                       <= 1'b1;
                        bus.sdram_error                          <= 1'b1;
                    end
`endif
                end
                RD_WAIT: begin
                    if (bus.new_sdram_controller_0_s1_readdatavalid) begin
                        state              <= DONE;
                        bus.sdram_readdata <= bus.new_sdram_controller_0_s1_readdata;
                        bus.sdram_finished <= 1'b1;
                    end
`ifdef SDRAM_TIMEOUT_EN
                    else if (wdog_hit) begin
                        state              <= DONE;
                        bus.sdram_readdata <= DATA_W'(SDRAM_TIMEOUT_DATA);
                        bus.sdram_finished <= 1'b1;
                        bus.sdram_error    <= 1'b1;
                    end
`endif
                end
                WR_REQ: begin
                    if (!bus.new_sdram_controller_0_s1_waitrequest) begin
                        state                                   <= DONE;
                        bus.new_sdram_controller_0_s1_chipselect <= 1'b0;
                        bus.new_sdram_controller_0_s1_write_n    <= 1'b1;
                        bus.sdram_finished                       <= 1'b1;
                    end
`ifdef SDRAM_TIMEOUT_EN
                    else if (wdog_hit) begin
                        state                                   <= DONE;
                        bus.new_sdram_controller_0_s1_chipselect <= 1'b0;
                        bus.new_sdram_controller_0_s1_write_n    <= 1'b1;
                        bus.sdram_finished                       <= 1'b1;
                        bus.sdram_error                          <= 1'b1;
                    end
`endif
                end
                DONE: begin
                    state          <= IDLE;
                    bus.sdram_busy <= 1'b0;
                end
                default: begin
                    state                                   <= IDLE;
                    bus.new_sdram_controller_0_s1_chipselect <= 1'b0;
                    bus.new_sdram_controller_0_s1_read_n     <= 1'b1;
                    bus.new_sdram_controller_0_s1_write_n    <= 1'b1;
                    bus.sdram_busy                           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_req_bridge.sv
// Scoreboard bench for sdram_req_bridge: requester, scripted Avalon responder and bus monitor.
// Timeout scenario runs only when SDRAM_TIMEOUT_EN is defined.
module tb_sdram_req_bridge;

    typedef struct {
        bit          is_wr;
        logic [22:0] addr;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int          fin;
    } rsp_t;

    logic clk = 1'b0;
    logic i_rst = 1'b0;
    int   cyc = 0;

    int n_chk = 0;
    int n_err = 0;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    int ws_cfg = 0;
    int ws_left = 0;
    int rd_lat_cfg = 1;
    int rd_cd = 0;
    logic [31:0] rd_data_cfg = '0;

    int fin_cnt = 0;
    int wr_acc = 0;
    int rdn_cyc = 0;
    int busy_cyc = 0;

    sdram_req_bridge_if bus ();

    sdram_req_bridge #(
        .ADDR_W     (23),
        .DATA_W     (32),
        .TIMEOUT_CYC(16)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Avalon responder: waitrequest for ws_cfg cycles per command, readdatavalid rd_lat_cfg cycles after acceptance.
    always @(posedge clk) begin
        #1;
        bus.new_sdram_controller_0_s1_readdatavalid = 1'b0;
        if (!bus.new_sdram_controller_0_s1_chipselect) begin
            ws_left = ws_cfg;
            bus.new_sdram_controller_0_s1_waitrequest = 1'b0;
        end else if (ws_left > 0) begin
            bus.new_sdram_controller_0_s1_waitrequest = 1'b1;
            ws_left--;
        end else begin
            bus.new_sdram_controller_0_s1_waitrequest = 1'b0;
        end
        if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) begin
                bus.new_sdram_controller_0_s1_readdatavalid = 1'b1;
                bus.new_sdram_controller_0_s1_readdata = rd_data_cfg;
            end
        end
    end

    // Bus monitor on the falling edge.
    always @(negedge clk) begin
        if (i_rst) begin
            if (bus.new_sdram_controller_0_s1_chipselect) begin
                chk("no_dual_cmd", 64'(!bus.new_sdram_controller_0_s1_read_n && !bus.new_sdram_controller_0_s1_write_n), 64'd0);
                if (!bus.new_sdram_controller_0_s1_read_n) rdn_cyc++;
                if (!bus.new_sdram_controller_0_s1_waitrequest) begin
                    if (cmd_q.size() == 0) begin
                        chk("acc_unexp", 64'(cmd_q.size()), 64'd1);
                    end else begin
                        cmd_t c;
                        c = cmd_q.pop_front();
                        chk("acc_addr", 64'(bus.new_sdram_controller_0_s1_address), 64'(c.addr));
                        chk("acc_is_wr", 64'(!bus.new_sdram_controller_0_s1_write_n), 64'(c.is_wr));
                        if (c.is_wr) begin
                            wr_acc++;
                            chk("acc_wdata", 64'(bus.new_sdram_controller_0_s1_writedata), 64'(c.data));
                        end else begin
                            rd_cd = rd_lat_cfg;
                        end
                    end
                end
            end
            if (bus.sdram_busy) busy_cyc++;
            if (bus.sdram_finished) begin
                fin_cnt++;
                if (rsp_q.size() == 0) begin
                    chk("fin_unexp", 64'(rsp_q.size()), 64'd1);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("fin_cyc", 64'(cyc), 64'(r.fin));
                    if (r.is_rd) chk("rd_data", 64'(bus.sdram_readdata), 64'(r.data));
                end
            end
        end
    end

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rsp_q.size() <= target) return;
        end
        chk("fin_wait", 64'(rsp_q.size()), 64'(target));
    endtask

    task automatic push_cmd(input bit is_wr, input logic [22:0] a, input logic [31:0] d);
        cmd_t c;
        c.is_wr = is_wr; c.addr = a; c.data = d;
        cmd_q.push_back(c);
    endtask

    task automatic push_rsp(input bit is_rd, input logic [31:0] d, input int fin);
        rsp_t r;
        r.is_rd = is_rd; r.data = d; r.fin = fin;
        rsp_q.push_back(r);
    endtask

    task automatic do_write(input logic [22:0] a, input logic [31:0] d);
        push_cmd(1'b1, a, d);
        push_rsp(1'b0, '0, cyc + 2 + ws_cfg);
        bus.sdram_addr = a;
        bus.sdram_writedata = d;
        bus.sdram_write = 1'b1;
        wait_rsp(0);
        bus.sdram_write = 1'b0;
    endtask

    task automatic do_read(input logic [22:0] a, input logic [31:0] d);
        rd_data_cfg = d;
        push_cmd(1'b0, a, '0);
        push_rsp(1'b1, d, cyc + 2 + ws_cfg + rd_lat_cfg);
        bus.sdram_addr = a;
        bus.sdram_read = 1'b1;
        wait_rsp(0);
        bus.sdram_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int f0, w0, b0, r0, t0;
        bus.sdram_read = 1'b0;
        bus.sdram_write = 1'b0;
        bus.sdram_addr = '0;
        bus.sdram_writedata = '0;
        bus.new_sdram_controller_0_s1_readdata = '0;
        bus.new_sdram_controller_0_s1_readdatavalid = 1'b0;
        bus.new_sdram_controller_0_s1_waitrequest = 1'b0;

        repeat (3) tick();
        chk("rst_cs", 64'(bus.new_sdram_controller_0_s1_chipselect), 64'd0);
        chk("rst_read_n", 64'(bus.new_sdram_controller_0_s1_read_n), 64'd1);
        chk("rst_write_n", 64'(bus.new_sdram_controller_0_s1_write_n), 64'd1);
        chk("rst_addr", 64'(bus.new_sdram_controller_0_s1_address), 64'd0);
        chk("rst_rdata", 64'(bus.sdram_readdata), 64'd0);
        chk("rst_busy", 64'(bus.sdram_busy), 64'd0);
        chk("rst_error", 64'(bus.sdram_error), 64'd0);
        chk("byteen_n", 64'(bus.new_sdram_controller_0_s1_byteenable_n), 64'd0);
        i_rst = 1'b1;
        repeat (2) tick();

        // Single write, no stall: one acceptance, busy for two cycles.
        f0 = fin_cnt; w0 = wr_acc; b0 = busy_cyc;
        do_write(23'h000100, 32'h1234_5678);
        tick();
        chk("wr1_fin_cnt", 64'(fin_cnt - f0), 64'd1);
        chk("wr1_acc_cnt", 64'(wr_acc - w0), 64'd1);
        chk("wr1_busy_cyc", 64'(busy_cyc - b0), 64'd2);

        // Read with three stall cycles and data two cycles after acceptance.
        ws_cfg = 3; rd_lat_cfg = 2; f0 = fin_cnt; r0 = rdn_cyc;
        do_read(23'h7FFFFF, 32'hCAFE_F00D);
        repeat (3) tick();
        chk("rd1_read_n_cyc", 64'(rdn_cyc - r0), 64'd4);
        chk("rd1_fin_cnt", 64'(fin_cnt - f0), 64'd1);
        chk("rd1_rdata_hold", 64'(bus.sdram_readdata), 64'hCAFE_F00D);
        ws_cfg = 0; rd_lat_cfg = 1;

        // Plain read at minimum latency.
        do_read(23'h012345, 32'hA5A5_0F0F);

        // Read and write together: write first, read afterwards while still held.
        rd_data_cfg = 32'h0BAD_CAFE;
        push_cmd(1'b1, 23'h000222, 32'h1111_2222);
        push_cmd(1'b0, 23'h000222, '0);
        push_rsp(1'b0, '0, cyc + 2);
        push_rsp(1'b1, 32'h0BAD_CAFE, cyc + 6);
        bus.sdram_addr = 23'h000222;
        bus.sdram_writedata = 32'h1111_2222;
        bus.sdram_write = 1'b1;
        bus.sdram_read = 1'b1;
        wait_rsp(1);
        bus.sdram_write = 1'b0;
        wait_rsp(0);
        bus.sdram_read = 1'b0;

        // Read and write together, both dropped after the write: read is not serviced.
        f0 = fin_cnt;
        push_cmd(1'b1, 23'h000333, 32'h3333_4444);
        push_rsp(1'b0, '0, cyc + 2);
        bus.sdram_addr = 23'h000333;
        bus.sdram_writedata = 32'h3333_4444;
        bus.sdram_write = 1'b1;
        bus.sdram_read = 1'b1;
        wait_rsp(0);
        bus.sdram_write = 1'b0;
        bus.sdram_read = 1'b0;
        repeat (6) tick();
        chk("drop_rd_fin_cnt", 64'(fin_cnt - f0), 64'd1);
        chk("drop_rd_cmd_q", 64'(cmd_q.size()), 64'd0);

        // Back-to-back writes with the request re-raised right after completion.
        f0 = fin_cnt; w0 = wr_acc;
        do_write(23'h000400, 32'hDEAD_0001);
        tick();
        do_write(23'h000404, 32'hDEAD_0002);
        repeat (3) tick();
        chk("b2b_acc_cnt", 64'(wr_acc - w0), 64'd2);
        chk("b2b_fin_cnt", 64'(fin_cnt - f0), 64'd2);

        // Reset in RD_WAIT, followed by a stale readdatavalid.
        rd_lat_cfg = 5; rd_data_cfg = 32'h5555_AAAA; f0 = fin_cnt;
        push_cmd(1'b0, 23'h000777, '0);
        bus.sdram_addr = 23'h000777;
        bus.sdram_read = 1'b1;
        repeat (2) tick();
        i_rst = 1'b0;
        bus.sdram_read = 1'b0;
        #1;
        chk("mid_rst_cs", 64'(bus.new_sdram_controller_0_s1_chipselect), 64'd0);
        chk("mid_rst_read_n", 64'(bus.new_sdram_controller_0_s1_read_n), 64'd1);
        chk("mid_rst_busy", 64'(bus.sdram_busy), 64'd0);
        chk("mid_rst_rdata", 64'(bus.sdram_readdata), 64'd0);
        chk("mid_rst_addr", 64'(bus.new_sdram_controller_0_s1_address), 64'd0);
        cmd_q.delete();
        rsp_q.delete();
        repeat (2) tick();
        i_rst = 1'b1;
        repeat (6) tick();
        chk("stale_fin_cnt", 64'(fin_cnt - f0), 64'd0);
        chk("stale_rdata", 64'(bus.sdram_readdata), 64'd0);
        chk("stale_busy", 64'(bus.sdram_busy), 64'd0);
        rd_lat_cfg = 1;

`ifdef SDRAM_TIMEOUT_EN
        // Read stalled forever: watchdog completes it with the poison value and latches the error.
        ws_cfg = 1000;
        t0 = cyc;
        push_rsp(1'b1, 32'hDEAD_BEEF, t0 + 17);
        bus.sdram_addr = 23'h000055;
        bus.sdram_read = 1'b1;
        wait_rsp(0);
        bus.sdram_read = 1'b0;
        ws_cfg = 0;
        chk("tmo_error", 64'(bus.sdram_error), 64'd1);
        do_write(23'h000066, 32'h7777_8888);
        chk("tmo_error_sticky", 64'(bus.sdram_error), 64'd1);
`else
        t0 = cyc;
        do_write(23'h000066, 32'h7777_8888);
        chk("err_tied_low", 64'(bus.sdram_error), 64'd0);
        chk("err_wr_fin_cyc", 64'(cyc), 64'(t0 + 3));
`endif

        repeat (2) tick();
        chk("end_cmd_q", 64'(cmd_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
